pixel_scan_gen: RTL and testbench
=================================

// Module: pixel_scan_gen
// PURPOSE
// Raster coordinate sequencer sitting directly upstream of the ray-marcher top (fullModule).
// Walks x=0..H_RES-1 and y=0..V_RES-1 and emits Q11.21 screen_x/screen_y with a 1-cycle valid pulse per pixel.
// Throttles issue by counting pixels in flight against fullModule's valid_out completions.
// Reports frame boundaries and counts frames; replaces the hand-driven per-pixel stimulus loop in hardware.
// PARAMETERS
// H_RES         640  pixels per line
// V_RES         480  lines per frame
// MAX_INFLIGHT  1    max issued-but-uncompleted pixels (>=1)
// FRAC_BITS     21   fractional bits of output coords (Q11.21)
// PORTS
// clk           in   1   system clock
// rst_gen       in   1   synchronous reset, active-low
// start         in   1   pulse: begin frame (ignored unless IDLE)
// continuous    in   1   1: auto-restart next frame after frame_done
// pixel_done    in   1   completion strobe (fullModule valid_out), 1 per pixel
// screen_x      out  32  x coordinate, Q11.21
// screen_y      out  32  y coordinate, Q11.21
// coord_valid   out  1   1-cycle pulse: screen_x/y valid this cycle
// first_px      out  1   high with coord_valid for (0,0)
// last_in_line  out  1   high with coord_valid when x==H_RES-1
// busy          out  1   state != IDLE
// frame_done    out  1   1-cycle pulse: last pixel of frame completed
// frame_count   out  16  completed frames, wraps 0xFFFF->0
// err_underflow out  1   sticky: pixel_done seen with inflight==0
// BEHAVIOUR
// - rst_gen==0 at posedge: state=IDLE; x=y=0; inflight=0; all outputs 0 (screen_x/y=0, frame_count=0, err cleared).
// - States: IDLE -start-> RUN; RUN -issue of (H_RES-1,V_RES-1)-> DRAIN; DRAIN -inflight==0-> IDLE or RUN (continuous).
// - Issue (RUN only): when inflight < MAX_INFLIGHT, register coords and pulse coord_valid next cycle.
// - coord_valid is registered; screen_x/y/first_px/last_in_line hold until the next issue.
// - No issue in the cycle start is accepted; first coord_valid is 2 cycles after start sampled high.
// - Coord format: screen_x = {x,FRAC_BITS'b0} zero-extended to 32; same for y. x,y are unsigned.
// - Counters: x++ per issue; at H_RES-1, x=0 and y++; at (H_RES-1,V_RES-1), go to DRAIN.
// - inflight: +1 on issue, -1 on pixel_done; both in same cycle -> unchanged.
// - MAX_INFLIGHT=1: next issue no earlier than the cycle after pixel_done.
// - Back-to-back issues allowed when MAX_INFLIGHT>1.
// - pixel_done with inflight==0: ignored (no decrement); err_underflow set until reset.
// - DRAIN exit: frame_done pulses one cycle; frame_count++ (wraps); x=y=0.
//   - continuous==1: RUN, re-issue from the next cycle.
//   - else: IDLE.
// - start while busy: ignored. continuous sampled only at DRAIN exit.
// - Reset mid-frame: immediate return to IDLE; in-flight completions after reset count as underflow.
// CONFIGURATION
// - SCAN_GEN_PIXEL_CENTRE_EN defined: coords offset by +0.5 px, i.e. bit FRAC_BITS-1 set in screen_x and screen_y.
//   Samples the pixel centre; e.g. x=3 -> 0x0070_0000.
// - Not defined: integer-aligned coords, low FRAC_BITS bits all zero.
// TESTING (H_RES=4, V_RES=2 unless noted)
// 1 Reset: rst_gen=0 2 cycles -> all outputs 0, busy=0; start during reset has no effect.
// 2 Single frame, MAX_INFLIGHT=1, pixel_done 3 cycles after each coord_valid:
//   -> 8 pulses, screen_x 0,0x200000,0x400000,0x600000 per line; screen_y 0 then 0x200000;
//   -> first_px on pulse 1 only; last_in_line on pulses 4 and 8;
//   -> frame_done 1 cycle after 8th pixel_done; frame_count=1; busy=0.
// 3 MAX_INFLIGHT=3, pixel_done held 0 -> exactly 3 coord_valid then stall;
//   1 pixel_done -> exactly 1 more issue; simultaneous issue+done keeps inflight=3.
// 4 continuous=1 across 3 frames -> frame_count 1,2,3; (0,0) re-issued 1 cycle after each frame_done.
// 5 pixel_done in IDLE -> err_underflow=1 and stays 1; start mid-frame ignored (pixel sequence unchanged).
// 6 Reset after 5th issue -> IDLE, x=y=0; new start restarts at (0,0).
//   With SCAN_GEN_PIXEL_CENTRE_EN, (1,1) -> screen_x=screen_y=0x0030_0000.

Source files
------------

// File: rtl/pixel_scan_gen.sv
// Raster coordinate sequencer: issues Q(32-FRAC_BITS).FRAC_BITS pixel coordinates, throttled by completions.
// Optional build macro SCAN_GEN_PIXEL_CENTRE_EN offsets every coordinate by +0.5 px.
module pixel_scan_gen #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int MAX_INFLIGHT = 1,
  parameter int FRAC_BITS    = 21
) (
  input  logic        clk,
  input  logic        rst_gen,
  input  logic        start,
  input  logic        continuous,
  input  logic        pixel_done,
  output logic [31:0] screen_x,
  output logic [31:0] screen_y,
  output logic        coord_valid,
  output logic        first_px,
  output logic        last_in_line,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        err_underflow
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

`ifdef SCAN_GEN_PIXEL_CENTRE_EN
  localparam logic [31:0] CENTRE = 32'(1) << (FRAC_BITS - 1);
`else
  localparam logic [31:0] CENTRE = 32'd0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [IW-1:0]   inflight;
  logic            issue;
  logic            retire;
  logic            last_x;
  logic            last_y;

  // A completion only retires a pixel if one is actually outstanding.
  assign issue  = (state == RUN) && (inflight < IW'(MAX_INFLIGHT));
  assign retire = pixel_done && (inflight != '0);
  assign last_x = (x == XW'(H_RES - 1));
  assign last_y = (y == YW'(V_RES - 1));
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_gen) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      inflight      <= '0;
      screen_x      <= '0;
      screen_y      <= '0;
      coord_valid   <= 1'b0;
      first_px      <= 1'b0;
      last_in_line  <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
      err_underflow <= 1'b0;
    end else begin
      coord_valid <= 1'b0;
      frame_done  <= 1'b0;

      if (pixel_done && (inflight == '0))
        err_underflow <= 1'b1;

      case ({issue, retire})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase

      case (state)
        IDLE: begin
          if (start)
            state <= RUN;
        end
        RUN: begin
          if (issue) begin
            coord_valid  <= 1'b1;
            screen_x     <= (32'(x) << FRAC_BITS) | CENTRE;
            screen_y     <= (32'(y) << FRAC_BITS) | CENTRE;
            first_px     <= (x == '0) && (y == '0);
            last_in_line <= last_x;
            if (last_x) begin
              x <= '0;
              if (last_y) begin
                y     <= '0;
                state <= DRAIN;
              end else begin
                y <= y + YW'(1);
              end
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        DRAIN: begin
          // Frame is finished only once every issued pixel has come back.
          if (inflight == '0) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            x           <= '0;
            y           <= '0;
            state       <= continuous ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Bench for pixel_scan_gen: two instances (MAX_INFLIGHT 1 and 3) on a 4x2 raster, checked every cycle
// against a pixel-index model plus directed literal expectations.
module tb_pixel_scan_gen;

  localparam int H = 4;
  localparam int V = 2;
  localparam int FB = 21;
  localparam int NPIX = H * V;

`ifdef SCAN_GEN_PIXEL_CENTRE_EN
  localparam logic [31:0] CTR = 32'h1 << (FB - 1);
`else
  localparam logic [31:0] CTR = 32'h0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  // Instance A: MAX_INFLIGHT=1, auto-completion 3 cycles after each pulse
  logic rst_a, start_a, cont_a, pd_a, pd_man_a;
  logic pd_auto_a = 1'b0;
  logic [31:0] sx_a, sy_a;
  logic cv_a, fp_a, lil_a, busy_a, fd_a, err_a;
  logic [15:0] fc_a;
  assign pd_a = pd_auto_a | pd_man_a;

  // Instance B: MAX_INFLIGHT=3, completions driven by hand
  logic rst_b, start_b, cont_b, pd_b;
  logic [31:0] sx_b, sy_b;
  logic cv_b, fp_b, lil_b, busy_b, fd_b, err_b;
  logic [15:0] fc_b;

  pixel_scan_gen #(.H_RES(H), .V_RES(V), .MAX_INFLIGHT(1), .FRAC_BITS(FB)) dut_a (
    .clk(clk), .rst_gen(rst_a), .start(start_a), .continuous(cont_a), .pixel_done(pd_a),
    .screen_x(sx_a), .screen_y(sy_a), .coord_valid(cv_a), .first_px(fp_a),
    .last_in_line(lil_a), .busy(busy_a), .frame_done(fd_a), .frame_count(fc_a),
    .err_underflow(err_a)
  );

  pixel_scan_gen #(.H_RES(H), .V_RES(V), .MAX_INFLIGHT(3), .FRAC_BITS(FB)) dut_b (
    .clk(clk), .rst_gen(rst_b), .start(start_b), .continuous(cont_b), .pixel_done(pd_b),
    .screen_x(sx_b), .screen_y(sy_b), .coord_valid(cv_b), .first_px(fp_b),
    .last_in_line(lil_b), .busy(busy_b), .frame_done(fd_b), .frame_count(fc_b),
    .err_underflow(err_b)
  );

  // Model: tracks the index of the next pixel to issue rather than x/y counters.
  typedef struct packed {
    logic        active;
    logic [7:0]  nxt;
    logic [7:0]  infl;
    logic [15:0] fcnt;
    logic        err;
    logic        cv;
    logic [31:0] sx;
    logic [31:0] sy;
    logic        fp;
    logic        lil;
    logic        fd;
  } mst_t;

  mst_t ma = '0;
  mst_t mb = '0;

  function automatic mst_t step(input mst_t s, input logic rn, input logic st, input logic ct,
                                input logic pd, input int mx);
    mst_t n;
    int nx;
    int inf;
    n = s;
    n.cv = 1'b0;
    n.fd = 1'b0;
    if (!rn) return '0;
    nx = int'(s.nxt);
    inf = int'(s.infl);
    if (pd) begin
      if (inf == 0) n.err = 1'b1;
      else inf = inf - 1;
    end
    if (!s.active) begin
      if (st) n.active = 1'b1;
    end else if (nx < NPIX) begin
      if (int'(s.infl) < mx) begin
        n.cv  = 1'b1;
        n.sx  = 32'((nx % H) << FB) | CTR;
        n.sy  = 32'((nx / H) << FB) | CTR;
        n.fp  = (nx == 0);
        n.lil = ((nx % H) == H - 1);
        n.nxt = 8'(nx + 1);
        inf = inf + 1;
      end
    end else if (s.infl == 0) begin
      n.fd = 1'b1;
      n.fcnt = s.fcnt + 16'd1;
      n.nxt = 8'd0;
      n.active = ct;
    end
    n.infl = 8'(inf);
    return n;
  endfunction

  always @(posedge clk) begin
    ma = step(ma, rst_a, start_a, cont_a, pd_a, 1);
    mb = step(mb, rst_b, start_b, cont_b, pd_b, 3);
  end

  task automatic cmp(input string nm, input logic [5:0] af, input logic [5:0] ef,
                     input logic [31:0] ax, input logic [31:0] ex,
                     input logic [31:0] ay, input logic [31:0] ey,
                     input logic [15:0] ac, input logic [15:0] ec);
    total++;
    if (af !== ef || ax !== ex || ay !== ey || ac !== ec) begin
      bad++;
      $display("FAIL %s cyc=%0d flags(cv,fp,lil,busy,fd,err) got=%b exp=%b x got=%h exp=%h y got=%h exp=%h count got=%0d exp=%0d",
               nm, cyc, af, ef, ax, ex, ay, ey, ac, ec);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("inst_a", {cv_a, fp_a, lil_a, busy_a, fd_a, err_a},
          {ma.cv, ma.fp, ma.lil, ma.active, ma.fd, ma.err}, sx_a, ma.sx, sy_a, ma.sy, fc_a, ma.fcnt);
      cmp("inst_b", {cv_b, fp_b, lil_b, busy_b, fd_b, err_b},
          {mb.cv, mb.fp, mb.lil, mb.active, mb.fd, mb.err}, sx_b, mb.sx, sy_b, mb.sy, fc_b, mb.fcnt);
    end
  end

  // Completion responder and pulse logger for instance A
  int due_q[$];
  logic [31:0] lx[$];
  logic [31:0] ly[$];
  logic [1:0]  lf[$];
  int ncv_b = 0;

  always @(negedge clk) begin
    if (cv_a === 1'b1) begin
      due_q.push_back(cyc + 3);
      lx.push_back(sx_a);
      ly.push_back(sy_a);
      lf.push_back({fp_a, lil_a});
    end
    pd_auto_a = 1'b0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      pd_auto_a = 1'b1;
      void'(due_q.pop_front());
    end
    if (cv_b === 1'b1) ncv_b++;
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_fd(input bit inst_b, input int budget, input string nm);
    int k;
    k = 0;
    while (k < budget && !((inst_b ? fd_b : fd_a) === 1'b1)) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= budget) begin
      bad++;
      $display("FAIL %s: frame_done not seen within %0d cycles", nm, budget);
    end
  endtask

  task automatic check_seq(input string nm);
    logic [31:0] xtab [4];
    xtab = '{32'h0, 32'h20_0000, 32'h40_0000, 32'h60_0000};
    lit({nm, "_npulses"}, 32'(lx.size()), 32'd8);
    for (int i = 0; i < lx.size() && i < 8; i++) begin
      lit($sformatf("%s_x%0d", nm, i), lx[i], xtab[i % 4] | CTR);
      lit($sformatf("%s_y%0d", nm, i), ly[i], ((i < 4) ? 32'h0 : 32'h20_0000) | CTR);
      lit($sformatf("%s_flags%0d", nm, i), 32'(lf[i]), 32'({i == 0, (i % 4) == 3}));
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  initial begin
    int n;
    rst_a = 0; rst_b = 0; start_a = 0; start_b = 0; cont_a = 0; cont_b = 0;
    pd_man_a = 0; pd_b = 0;
    @(posedge clk);
    #1 chk_on = 1'b1;

    // Reset, with start asserted during it
    @(negedge clk); start_a = 1; start_b = 1;
    @(negedge clk); start_a = 0; start_b = 0;
    @(negedge clk);
    lit("rst_busy", 32'(busy_a), 32'd0);
    lit("rst_sx", sx_a, 32'd0);
    lit("rst_count", 32'(fc_a), 32'd0);
    lit("rst_err", 32'(err_a), 32'd0);
    rst_a = 1; rst_b = 1;
    @(negedge clk);
    lit("rst_start_ignored", 32'(busy_a), 32'd0);

    // Single frame with MAX_INFLIGHT=1
    lx.delete(); ly.delete(); lf.delete();
    start_a = 1;
    @(negedge clk); start_a = 0;
    lit("t2_no_pulse_yet", 32'(cv_a), 32'd0);
    @(negedge clk);
    lit("t2_first_pulse", 32'(cv_a), 32'd1);
    lit("t2_first_x", sx_a, CTR);
    wait_fd(1'b0, 200, "t2_frame");
    @(negedge clk);
    lit("t2_count", 32'(fc_a), 32'd1);
    lit("t2_busy", 32'(busy_a), 32'd0);
    check_seq("t2");

    // Completion in IDLE, then start mid-frame
    pd_man_a = 1;
    @(negedge clk); pd_man_a = 0;
    @(negedge clk);
    lit("t5_err_set", 32'(err_a), 32'd1);
    lx.delete(); ly.delete(); lf.delete();
    pulse_start_a();
    repeat (12) @(negedge clk);
    pulse_start_a();
    wait_fd(1'b0, 200, "t5_frame");
    @(negedge clk);
    lit("t5_count", 32'(fc_a), 32'd2);
    lit("t5_err_sticky", 32'(err_a), 32'd1);
    check_seq("t5");

    // Reset after the fifth issue, then restart
    pulse_start_a();
    n = 0;
    for (int k = 0; k < 200 && n < 5; k++) begin
      @(negedge clk);
      if (cv_a === 1'b1) n++;
    end
    lit("t6_five_issued", 32'(n), 32'd5);
    rst_a = 0;
    repeat (5) @(negedge clk);
    lit("t6_busy", 32'(busy_a), 32'd0);
    lit("t6_sx", sx_a, 32'd0);
    lit("t6_count", 32'(fc_a), 32'd0);
    lit("t6_err", 32'(err_a), 32'd0);
    rst_a = 1;
    @(negedge clk);
    lx.delete(); ly.delete(); lf.delete();
    pulse_start_a();
    wait_fd(1'b0, 200, "t6_frame");
    @(negedge clk);
    lit("t6_count_after", 32'(fc_a), 32'd1);
    check_seq("t6");

    // Continuous mode across three frames
    rst_a = 0;
    repeat (5) @(negedge clk);
    rst_a = 1; cont_a = 1;
    @(negedge clk);
    pulse_start_a();
    for (int f = 1; f <= 3; f++) begin
      wait_fd(1'b0, 200, $sformatf("t4_frame%0d", f));
      @(negedge clk);
      lit($sformatf("t4_count%0d", f), 32'(fc_a), 32'(f));
      lit($sformatf("t4_reissue%0d", f), 32'(cv_a), (f < 3) ? 32'd1 : 32'd0);
      if (f < 3) lit($sformatf("t4_reissue_x%0d", f), sx_a, CTR);
      if (f == 2) cont_a = 0;
    end
    lit("t4_busy_end", 32'(busy_a), 32'd0);

    // MAX_INFLIGHT=3 throttling on instance B
    start_b = 1;
    @(negedge clk); start_b = 0;
    repeat (12) @(negedge clk);
    lit("t3_stall_at3", 32'(ncv_b), 32'd3);
    lit("t3_busy", 32'(busy_b), 32'd1);
    pd_b = 1;
    @(negedge clk); pd_b = 0;
    repeat (8) @(negedge clk);
    lit("t3_one_more", 32'(ncv_b), 32'd4);
    pd_b = 1;
    repeat (2) @(negedge clk);
    pd_b = 0;
    repeat (8) @(negedge clk);
    lit("t3_simul", 32'(ncv_b), 32'd6);
    pd_b = 1;
    wait_fd(1'b1, 100, "t3_frame");
    pd_b = 0;
    @(negedge clk);
    lit("t3_count", 32'(fc_b), 32'd1);
    lit("t3_busy_end", 32'(busy_b), 32'd0);
    lit("t3_npulses", 32'(ncv_b), 32'd8);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
